// File: rtl/fp32_pkg.sv
// Shared types and constants for the sequential binary32 adder.
package fp32_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_UNPACK,
      S_SPECIAL,
      S_ALIGN,
      S_ADD_0,
      S_ADD_1,
      S_NORM_1,
      S_NORM_2,
      S_ROUND,
      S_PACK,
      S_PUT_Z
   } state_e;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MIN  = -126;
   localparam int EXP_MAX  = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

endpackage

// File: rtl/fp32_special.sv
// Combinational classifier for NaN / infinity / zero operand pairs that
// bypass the arithmetic datapath.
module fp32_special
   import fp32_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        is_special_o,
   output logic [31:0] result_o
);

   fp32_t a;
   fp32_t b;
   logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   assign a = a_i;
   assign b = b_i;

   assign a_nan  = (a.exp == 8'hFF) && (a.frac != '0);
   assign b_nan  = (b.exp == 8'hFF) && (b.frac != '0);
   assign a_inf  = (a.exp == 8'hFF) && (a.frac == '0);
   assign b_inf  = (b.exp == 8'hFF) && (b.frac == '0);
   assign a_zero = (a.exp == 8'h00) && (a.frac == '0);
   assign b_zero = (b.exp == 8'h00) && (b.frac == '0);

   // NOTE: both outputs get a default first so no path through the if-chain can infer a latch.
   always_comb begin
      is_special_o = 1'b1;
      result_o     = QNAN;
      if (a_nan || b_nan) begin
         result_o = QNAN;
      end else if (a_inf && b_inf && (a.sign != b.sign)) begin
         result_o = QNAN;
      end else if (a_inf) begin
         result_o = a_i;
      end else if (b_inf) begin
         result_o = b_i;
      end else if (a_zero && b_zero) begin
         result_o = {a.sign & b.sign, 31'b0};
      end else if (a_zero) begin
         result_o = b_i;
      end else if (b_zero) begin
         result_o = a_i;
      end else begin
         is_special_o = 1'b0;
         result_o     = '0;
      end
   end

endmodule

// File: rtl/fp32_adder.sv
// Sequential IEEE-754 binary32 adder: fetches A then B over strobe/ack
// handshakes, walks a multi-cycle datapath, and holds the sum until accepted.
module fp32_adder
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic [31:0] input_b,
   input  logic        input_a_stb,
   input  logic        input_b_stb,
   input  logic        ack_output,
   input  logic        start,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   output logic        input_a_ack,
   output logic        input_b_ack,
   output logic        idle_status,
   output logic        output_valid
);

   localparam logic signed [9:0] E_MIN  = 10'(EXP_MIN);
   localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);
   localparam logic signed [9:0] E_BIAS = 10'(EXP_BIAS);

   state_e            state_q;
   fp32_t             a_q, b_q;
   logic [26:0]       a_m_q, b_m_q;
   logic signed [9:0] a_e_q, b_e_q, z_e_q;
   logic              a_s_q, b_s_q, z_s_q;
   logic [27:0]       sum_q;
   logic [23:0]       z_m_q;
   logic              guard_q, round_q, sticky_q;
   logic [31:0]       z_q;
   logic              z_stb_q, a_ack_q, b_ack_q, idle_q, valid_q;

   logic              is_special;
   logic [31:0]       special_z;
   logic [24:0]       z_m_inc;
   logic signed [9:0] z_biased;

   fp32_special u_special (
      .a_i          (a_q),
      .b_i          (b_q),
      .is_special_o (is_special),
      .result_o     (special_z)
   );

   assign z_m_inc  = {1'b0, z_m_q} + 25'd1;
   assign z_biased = z_e_q + E_BIAS;

   // NOTE: every register here is state, so all updates are non-blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         a_m_q    <= '0;
         b_m_q    <= '0;
         a_e_q    <= '0;
         b_e_q    <= '0;
         z_e_q    <= '0;
         a_s_q    <= 1'b0;
         b_s_q    <= 1'b0;
         z_s_q    <= 1'b0;
         sum_q    <= '0;
         z_m_q    <= '0;
         guard_q  <= 1'b0;
         round_q  <= 1'b0;
         sticky_q <= 1'b0;
         z_q      <= '0;
         z_stb_q  <= 1'b0;
         a_ack_q  <= 1'b0;
         b_ack_q  <= 1'b0;
         idle_q   <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               valid_q <= 1'b0;
               idle_q  <= 1'b0;
               a_ack_q <= 1'b1;
               state_q <= S_GET_A;
            end
            S_GET_A: if (input_a_stb && a_ack_q) begin
               a_q     <= input_a;
               a_ack_q <= 1'b0;
               b_ack_q <= 1'b1;
               state_q <= S_GET_B;
            end
            S_GET_B: if (input_b_stb && b_ack_q) begin
               b_q     <= input_b;
               b_ack_q <= 1'b0;
               state_q <= S_UNPACK;
            end
            S_UNPACK: begin
               a_s_q   <= a_q.sign;
               b_s_q   <= b_q.sign;
               a_m_q   <= {a_q.exp != 8'h00, a_q.frac, 3'b000};
               b_m_q   <= {b_q.exp != 8'h00, b_q.frac, 3'b000};
               a_e_q   <= (a_q.exp == 8'h00) ? E_MIN : $signed({2'b00, a_q.exp}) - E_BIAS;
               b_e_q   <= (b_q.exp == 8'h00) ? E_MIN : $signed({2'b00, b_q.exp}) - E_BIAS;
               state_q <= S_SPECIAL;
            end
            S_SPECIAL: if (is_special) begin
               z_q     <= special_z;
               z_stb_q <= 1'b1;
               state_q <= S_PUT_Z;
            end else begin
               state_q <= S_ALIGN;
            end
            // Once only the sticky bit can remain, further shifts are no-ops, so jump the exponent.
            S_ALIGN: if (a_e_q > b_e_q) begin
               if (b_m_q[26:1] == '0) begin
                  b_e_q <= a_e_q;
               end else begin
                  b_e_q <= b_e_q + 10'sd1;
                  b_m_q <= {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
               end
            end else if (a_e_q < b_e_q) begin
               if (a_m_q[26:1] == '0) begin
                  a_e_q <= b_e_q;
               end else begin
                  a_e_q <= a_e_q + 10'sd1;
                  a_m_q <= {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
               end
            end else begin
               state_q <= S_ADD_0;
            end
            S_ADD_0: begin
               z_e_q <= a_e_q;
               if (a_s_q == b_s_q) begin
                  sum_q <= {1'b0, a_m_q} + {1'b0, b_m_q};
                  z_s_q <= a_s_q;
               end else if (a_m_q >= b_m_q) begin
                  sum_q <= {1'b0, a_m_q} - {1'b0, b_m_q};
                  z_s_q <= a_s_q;
               end else begin
                  sum_q <= {1'b0, b_m_q} - {1'b0, a_m_q};
                  z_s_q <= b_s_q;
               end
               state_q <= S_ADD_1;
            end
            S_ADD_1: begin
               if (sum_q == '0) begin
                  z_s_q    <= 1'b0;
                  z_e_q    <= E_MIN;
                  z_m_q    <= '0;
                  guard_q  <= 1'b0;
                  round_q  <= 1'b0;
                  sticky_q <= 1'b0;
               end else if (sum_q[27]) begin
                  z_m_q    <= sum_q[27:4];
                  guard_q  <= sum_q[3];
                  round_q  <= sum_q[2];
                  sticky_q <= sum_q[1] | sum_q[0];
                  z_e_q    <= z_e_q + 10'sd1;
               end else begin
                  z_m_q    <= sum_q[26:3];
                  guard_q  <= sum_q[2];
                  round_q  <= sum_q[1];
                  sticky_q <= sum_q[0];
               end
               state_q <= S_NORM_1;
            end
            S_NORM_1: if (!z_m_q[23] && (z_e_q > E_MIN)) begin
               z_e_q   <= z_e_q - 10'sd1;
               z_m_q   <= {z_m_q[22:0], guard_q};
               guard_q <= round_q;
               round_q <= 1'b0;
            end else begin
               state_q <= S_NORM_2;
            end
            S_NORM_2: if (z_e_q < E_MIN) begin
               z_e_q    <= z_e_q + 10'sd1;
               z_m_q    <= {1'b0, z_m_q[23:1]};
               guard_q  <= z_m_q[0];
               round_q  <= guard_q;
               sticky_q <= sticky_q | round_q;
            end else begin
               state_q <= S_ROUND;
            end
            S_ROUND: begin
               if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                  if (z_m_inc[24]) begin
                     z_m_q <= 24'h80_0000;
                     z_e_q <= z_e_q + 10'sd1;
                  end else begin
                     z_m_q <= z_m_inc[23:0];
                  end
               end
               state_q <= S_PACK;
            end
            S_PACK: begin
               if (z_e_q > E_MAX) begin
                  z_q <= POS_INF | {z_s_q, 31'b0};
               end else begin
                  z_q <= {z_s_q, z_m_q[23] ? z_biased[7:0] : 8'h00, z_m_q[22:0]};
               end
               z_stb_q <= 1'b1;
               state_q <= S_PUT_Z;
            end
            S_PUT_Z: if (ack_output && z_stb_q) begin
               z_stb_q <= 1'b0;
               valid_q <= 1'b1;
               idle_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign output_z     = z_q;
   assign output_z_stb = z_stb_q;
   assign input_a_ack  = a_ack_q;
   assign input_b_ack  = b_ack_q;
   assign idle_status  = idle_q;
   assign output_valid = valid_q;

endmodule

// File: tb/tb_fp32_adder.sv
// Scoreboard bench for fp32_adder: expected sums are queued when operands are
// driven and compared when the adder presents and hands off its result.
module tb_fp32_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a, input_b;
   logic        input_a_stb, input_b_stb, ack_output, start;
   logic [31:0] output_z;
   logic        output_z_stb, input_a_ack, input_b_ack, idle_status, output_valid;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   fp32_adder dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_b      (input_b),
      .input_a_stb  (input_a_stb),
      .input_b_stb  (input_b_stb),
      .ack_output   (ack_output),
      .start        (start),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .input_a_ack  (input_a_ack),
      .input_b_ack  (input_b_ack),
      .idle_status  (idle_status),
      .output_valid (output_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   function automatic logic probe(input int sel);
      case (sel)
         0:       return idle_status;
         1:       return output_z_stb;
         2:       return input_b_ack;
         default: return input_a_ack;
      endcase
   endfunction

   task automatic wait_for(input int sel, input logic val, input string tag, output int cycles);
      cycles = 0;
      while (probe(sel) !== val && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      if (probe(sel) !== val) check({tag, "_timeout"}, {31'b0, probe(sel)}, {31'b0, val});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_z"},     output_z,     32'h0);
      check({tag, "_z_stb"}, output_z_stb, 32'h0);
      check({tag, "_a_ack"}, input_a_ack,  32'h0);
      check({tag, "_b_ack"}, input_b_ack,  32'h0);
      check({tag, "_idle"},  idle_status,  32'h1);
      check({tag, "_valid"}, output_valid, 32'h0);
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
      int c;
      @(negedge clk);
      input_a     = a;
      input_b     = b;
      input_a_stb = 1'b1;
      input_b_stb = 1'b1;
      ack_output  = 1'b1;
      start       = 1'b1;
      exp_q.push_back('{name, expv});
      wait_for(0, 1'b0, {name, "_leave_idle"}, c);
      start = 1'b0;
      wait_for(0, 1'b1, {name, "_return_idle"}, c);
      check({name, "_latency_le_80"}, {31'b0, c <= 80}, 32'd1);
      check({name, "_held"},  output_z,     expv);
      check({name, "_valid"}, output_valid, 32'd1);
   endtask

   // Results are sampled mid-low-phase, after the bench has settled its inputs.
   always @(negedge clk) begin : monitor
      exp_t e;
      #2;
      if (!rst && output_z_stb && ack_output) begin
         if (exp_q.size() == 0) begin
            check("result_without_stimulus", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check(e.name, output_z, e.value);
            check({e.name, "_valid_low_while_stb"}, output_valid, 32'd0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int c;
      rst         = 1'b1;
      input_a     = '0;
      input_b     = '0;
      input_a_stb = 1'b0;
      input_b_stb = 1'b0;
      ack_output  = 1'b0;
      start       = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("start_low_idle",  idle_status, 32'd1);
         check("start_low_a_ack", input_a_ack, 32'd0);
         check("start_low_b_ack", input_b_ack, 32'd0);
      end

      run_op("add_15p75_7p25",   32'h417C0000, 32'h40E80000, 32'h41B80000);
      check("idle_after_first",  idle_status, 32'd1);
      run_op("one_minus_one",    32'h3F800000, 32'hBF800000, 32'h00000000);
      run_op("neg_zero_pair",    32'h80000000, 32'h80000000, 32'h80000000);
      run_op("inf_minus_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000);
      run_op("nan_plus_one",     32'h7FC00000, 32'h3F800000, 32'h7FC00000);
      run_op("overflow_to_inf",  32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      run_op("tie_to_even",      32'h3F800000, 32'h33800000, 32'h3F800000);
      run_op("round_up",         32'h3F800000, 32'h33800001, 32'h3F800001);
      run_op("denorm_sum",       32'h00000001, 32'h00000001, 32'h00000002);
      run_op("one_plus_zero",    32'h3F800000, 32'h00000000, 32'h3F800000);
      run_op("neg5_plus_3",      32'hC0A00000, 32'h40400000, 32'hC0000000);
      run_op("huge_plus_tiny",   32'h7F000000, 32'h00000001, 32'h7F000000);

      // Consumer stalls: the result must stay presented and stable.
      @(negedge clk);
      input_a    = 32'hC0A00000;
      input_b    = 32'h40400000;
      ack_output = 1'b0;
      start      = 1'b1;
      exp_q.push_back('{"stall_result", 32'hC0000000});
      wait_for(0, 1'b0, "stall_leave_idle", c);
      start = 1'b0;
      wait_for(1, 1'b1, "stall_stb", c);
      for (int i = 0; i < 5; i++) begin
         check("stall_stb_held", output_z_stb, 32'd1);
         check("stall_z_stable", output_z,     32'hC0000000);
         @(negedge clk);
      end
      ack_output = 1'b1;
      wait_for(0, 1'b1, "stall_return_idle", c);

      // Operand B withheld: the block must wait in GET_B.
      @(negedge clk);
      input_a     = 32'h40000000;
      input_b     = 32'hBF800000;
      input_b_stb = 1'b0;
      start       = 1'b1;
      exp_q.push_back('{"b_withheld_result", 32'h3F800000});
      wait_for(0, 1'b0, "bwait_leave_idle", c);
      start = 1'b0;
      wait_for(2, 1'b1, "bwait_b_ack", c);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bwait_b_ack_held", input_b_ack,  32'd1);
         check("bwait_not_idle",   idle_status,  32'd0);
         check("bwait_no_result",  output_z_stb, 32'd0);
      end
      input_b_stb = 1'b1;
      wait_for(0, 1'b1, "bwait_return_idle", c);

      // Reset pulse while aligning a wide exponent gap.
      @(negedge clk);
      input_a = 32'h3F800000;
      input_b = 32'h35800000;
      start   = 1'b1;
      exp_q.push_back('{"aborted_result", 32'h3F800008});
      wait_for(2, 1'b1, "rst_b_ack_high", c);
      start = 1'b0;
      wait_for(2, 1'b0, "rst_b_ack_low", c);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_align_reset");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      run_op("after_reset", 32'h3F800000, 32'h35800000, 32'h3F800008);

      // Start held high: the next operation launches right after IDLE.
      @(negedge clk);
      input_a = 32'h3F800000;
      input_b = 32'h3F800000;
      start   = 1'b1;
      exp_q.push_back('{"b2b_first",  32'h40000000});
      exp_q.push_back('{"b2b_second", 32'h40000000});
      wait_for(0, 1'b0, "b2b_leave_idle", c);
      wait_for(0, 1'b1, "b2b_return_idle", c);
      @(negedge clk);
      check("b2b_restart", idle_status, 32'd0);
      start = 1'b0;
      wait_for(0, 1'b1, "b2b_second_idle", c);
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp32_adder.md
Name: fp32_adder

Overview:
- Sequential IEEE-754 binary32 adder with strobe/acknowledge handshakes on both operands and on the result.
- Fetches A, then B, then computes A+B through a multi-cycle state machine (unpack, special-case, align, add, normalise, round, pack).
- Presents the sum on output_z until it is acknowledged.
- Used as the add unit of the FPU; operation begins only when start is high.

Parameters:
- none: format is fixed to binary32 (8-bit exponent, bias 127, 23-bit fraction).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_a  input  32  operand A (binary32).
- input_b  input  32  operand B (binary32).
- input_a_stb  input  1  A valid.
- input_b_stb  input  1  B valid.
- ack_output  input  1  consumer accepts output_z.
- start  input  1  permission to begin a new operation.
- output_z  output  32  sum (binary32).
- output_z_stb  output  1  output_z valid, held until accepted.
- input_a_ack  output  1  A requested.
- input_b_ack  output  1  B requested.
- idle_status  output  1  high while in IDLE.
- output_valid  output  1  output_z holds the result of the last completed operation.

Behaviour:
- Interface: one clock, clk. Reset is rst: asynchronous, active-high.
- Reset values: state=IDLE, output_z=0, output_z_stb=0, input_a_ack=0, input_b_ack=0, idle_status=1, output_valid=0. Reset mid-operation aborts the operation and discards all operands.
- Conversion order: IDLE, GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z, back to IDLE.
- IDLE: if start=1, go to GET_A and clear output_valid. If start=0, stay.
- GET_A: input_a_ack=1. When input_a_stb & input_a_ack, capture input_a, drop ack, go to GET_B.
- GET_B: the same handshake using input_b, input_b_stb and input_b_ack.
- UNPACK: split each operand into sign, unbiased exponent and 24-bit significand (hidden bit set). A denormal operand uses exponent -126 and hidden bit 0.
- SPECIAL: result is written straight to PUT_Z when:
  - either operand is NaN -> 0x7FC00000.
  - inf + inf of opposite sign -> 0x7FC00000.
  - inf + anything else -> that inf.
  - both zero -> sign = sign_a AND sign_b.
  - one operand zero -> the other operand, unchanged.
- ALIGN: shift the smaller-exponent significand right 1 bit per cycle, OR-ing shifted-out bits into a sticky bit, until exponents are equal.
- ADD_0/ADD_1:
  - Significands carry 3 extra LSBs (guard, round, sticky).
  - Same signs: add. Different signs: subtract smaller from larger; result takes the sign of the larger.
  - A carry-out shifts right 1 and increments the exponent.
  - An exact-zero difference gives +0.
- NORM_1: while the hidden bit is 0 and exponent > -126, shift left 1 and decrement, one per cycle.
- NORM_2: while exponent < -126, shift right 1 and increment, keeping sticky.
- ROUND: round to nearest, ties to even. If rounding carries out of the significand, increment the exponent.
- PACK:
  - Exponent > 127 -> ±inf (0x7F800000 | sign).
  - Hidden bit 0 -> biased exponent field 0 (denormal).
- PUT_Z: output_z_stb=1, output_z=result. When ack_output & output_z_stb: drop strobe, set output_valid=1, go to IDLE.
- Hold behaviour: output_z holds its value after PUT_Z until overwritten by the next operation. output_valid stays high until the next start is accepted.
- Latency: with strobes, ack and start tied high, every result completes within 80 cycles of leaving IDLE.
- Back-to-back: with start held high, a new operation begins the cycle after IDLE is re-entered.

Decomposition:
- Shared package fp32_pkg contains:
  - state enum typedef.
  - EXP_BIAS=127, EXP_MIN=-126, EXP_MAX=127.
  - QNAN=32'h7FC0_0000, POS_INF=32'h7F80_0000.
- One natural sub-module: fp32_special, a combinational special-case classifier. It outputs an is_special flag and the special result word.

Test Plan:
- 15.75 (0x417C0000) + 7.25 (0x40E80000), stbs, ack and start tied high, rst=0 -> output_z=0x41B80000 (23.0); output_z_stb then output_valid asserted; idle_status high again afterwards.
- 1.0 (0x3F800000) + -1.0 (0xBF800000) -> 0x00000000. 0x80000000 + 0x80000000 -> 0x80000000.
- inf (0x7F800000) + -inf (0xFF800000) -> 0x7FC00000. NaN + 1.0 -> 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
- Rounding and denormals:
  - 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even).
  - 0x3F800000 + 0x33800001 -> 0x3F800001.
  - 0x00000001 + 0x00000001 -> 0x00000002.
- Handshake:
  - start=0 holds the block in IDLE with acks low.
  - ack_output low for 5 cycles keeps output_z_stb high with output_z stable.
  - input_b_stb withheld keeps the block in GET_B.
- rst pulse during ALIGN -> all outputs immediately return to reset values; the next operation computes correctly.
